// File: rtl/doorlock_pkg.sv
// Shared key codes, controller states and entry geometry for the keypad door lock.
package doorlock_pkg;

  localparam int unsigned PW_DIGITS = 4;

  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hB;
  localparam logic [3:0] KEY_CHPW  = 4'hC;

  typedef enum logic [2:0] {
    ST_ENTRY,
    ST_CHECK,
    ST_OPEN,
    ST_SET,
    ST_LOCKOUT
  } state_t;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/doorlock_timer.sv
// Loadable down-counter with zero flag; shared by the unlock and lockout intervals.
module doorlock_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/doorlock_entry_ctrl.sv
// Keypad entry sequencer: drives the external 4-digit shift register, checks the
// code, and manages unlock, password change and lockout after repeated failures.
module doorlock_entry_ctrl
  import doorlock_pkg::*;
#(
  parameter logic [15:0] DEFAULT_PW    = 16'h1234,
  parameter int unsigned UNLOCK_CYCLES = 50_000_000,
  parameter int unsigned LOCK_CYCLES   = 250_000_000,
  parameter int unsigned MAX_FAIL      = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           key_valid,
  input  logic [3:0]                     key_code,
  input  logic [15:0]                    entry_word,
  output logic                           sreg_ce,
  output logic [3:0]                     sreg_din,
  output logic                           sreg_clr,
  output logic [2:0]                     digit_cnt,
  output logic                           unlock,
  output logic                           err,
  output logic                           alarm,
  output logic [$clog2(MAX_FAIL+1)-1:0]  fail_cnt
);

  localparam int unsigned MAX_CYC = (UNLOCK_CYCLES > LOCK_CYCLES) ? UNLOCK_CYCLES : LOCK_CYCLES;
  localparam int unsigned TW      = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;
  localparam int unsigned FW      = $clog2(MAX_FAIL + 1);

  localparam logic [TW-1:0] UNLOCK_LOAD = TW'(UNLOCK_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LOAD   = TW'(LOCK_CYCLES - 1);
  localparam logic [FW-1:0] FAIL_LIMIT  = FW'(MAX_FAIL);
  localparam logic [2:0]    FULL        = 3'(PW_DIGITS);

  state_t        r_state, w_state_nxt;
  logic [2:0]    r_digit_cnt, w_digit_nxt;
  logic [FW-1:0] r_fail_cnt, w_fail_nxt, w_fail_inc;
  logic [15:0]   r_pw, w_pw_nxt;
  logic          r_err, w_err_nxt;
  logic          w_ce, w_clr, w_fail;
  logic          w_tmr_load, w_tmr_zero;
  logic [TW-1:0] w_tmr_val;

  doorlock_timer #(.WIDTH(TW)) u_timer (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_zero     (w_tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_ENTRY;
      r_digit_cnt <= '0;
      r_fail_cnt  <= '0;
      r_pw        <= DEFAULT_PW;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_digit_cnt <= w_digit_nxt;
      r_fail_cnt  <= w_fail_nxt;
      r_pw        <= w_pw_nxt;
      r_err       <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_digit_nxt = r_digit_cnt;
    w_fail_nxt  = r_fail_cnt;
    w_pw_nxt    = r_pw;
    w_err_nxt   = 1'b0;
    w_ce        = 1'b0;
    w_clr       = 1'b0;
    w_fail      = 1'b0;
    w_tmr_load  = 1'b0;
    w_tmr_val   = UNLOCK_LOAD;
    w_fail_inc  = r_fail_cnt + 1'b1;

    case (r_state)
      ST_ENTRY, ST_SET: begin
        if (key_valid) begin
          if (is_digit(key_code)) begin
            if (r_digit_cnt < FULL) begin
              w_ce        = 1'b1;
              w_digit_nxt = r_digit_cnt + 3'd1;
            end
          end else if (key_code == KEY_CLEAR) begin
            w_clr       = 1'b1;
            w_digit_nxt = '0;
          end else if (key_code == KEY_ENTER) begin
            if (r_state == ST_SET) begin
              w_clr       = 1'b1;
              w_digit_nxt = '0;
              w_state_nxt = ST_ENTRY;
              if (r_digit_cnt == FULL) w_pw_nxt = entry_word;
            end else if (r_digit_cnt == FULL) begin
              w_state_nxt = ST_CHECK;
            end else begin
              w_clr       = 1'b1;
              w_digit_nxt = '0;
              w_fail      = 1'b1;
            end
          end
        end
      end
      ST_CHECK: begin
        w_clr       = 1'b1;
        w_digit_nxt = '0;
        if (entry_word == r_pw) begin
          w_state_nxt = ST_OPEN;
          w_fail_nxt  = '0;
          w_tmr_load  = 1'b1;
          w_tmr_val   = UNLOCK_LOAD;
        end else begin
          w_fail = 1'b1;
        end
      end
      ST_OPEN: begin
        // Expiry has priority over a Change-password key in the same cycle.
        if (w_tmr_zero) begin
          w_state_nxt = ST_ENTRY;
        end else if (key_valid && key_code == KEY_CHPW) begin
          w_state_nxt = ST_SET;
          w_clr       = 1'b1;
        end
      end
      ST_LOCKOUT: begin
        if (w_tmr_zero) begin
          w_state_nxt = ST_ENTRY;
          w_fail_nxt  = '0;
        end
      end
      default: w_state_nxt = ST_ENTRY;
    endcase

    // Short codes and mismatches share one failure path.
    if (w_fail) begin
      w_err_nxt  = 1'b1;
      w_fail_nxt = w_fail_inc;
      if (w_fail_inc == FAIL_LIMIT) begin
        w_state_nxt = ST_LOCKOUT;
        w_tmr_load  = 1'b1;
        w_tmr_val   = LOCK_LOAD;
      end else begin
        w_state_nxt = ST_ENTRY;
      end
    end
  end

  assign sreg_ce   = ~rst & w_ce;
  assign sreg_clr  = rst | w_clr;
  assign sreg_din  = key_code;
  assign digit_cnt = r_digit_cnt;
  assign fail_cnt  = r_fail_cnt;
  assign err       = r_err;
  assign unlock    = (r_state == ST_OPEN);
  assign alarm     = (r_state == ST_LOCKOUT);

endmodule

// File: tb/tb_doorlock_entry_ctrl.sv
// Randomized and directed bench for doorlock_entry_ctrl against a deadline-based
// behavioural model of the keypad lock; includes the external shift register.
module tb_doorlock_entry_ctrl;

  localparam int unsigned U   = 8;
  localparam int unsigned L   = 16;
  localparam int unsigned MF  = 3;
  localparam logic [15:0] DPW = 16'h1234;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic [15:0] entry_word;
  logic        sreg_ce, sreg_clr, unlock, err, alarm;
  logic [3:0]  sreg_din;
  logic [2:0]  digit_cnt;
  logic [1:0]  fail_cnt;
  logic [15:0] r_sr = '0;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  doorlock_entry_ctrl #(
    .DEFAULT_PW   (DPW),
    .UNLOCK_CYCLES(U),
    .LOCK_CYCLES  (L),
    .MAX_FAIL     (MF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .entry_word(entry_word),
    .sreg_ce   (sreg_ce),
    .sreg_din  (sreg_din),
    .sreg_clr  (sreg_clr),
    .digit_cnt (digit_cnt),
    .unlock    (unlock),
    .err       (err),
    .alarm     (alarm),
    .fail_cnt  (fail_cnt)
  );

  // External 4-stage entry register, newest digit in [3:0].
  always_ff @(posedge clk) begin
    if (sreg_clr)     r_sr <= '0;
    else if (sreg_ce) r_sr <= {r_sr[11:0], sreg_din};
  end
  assign entry_word = r_sr;

  wire [7:0] w_act = {unlock, alarm, err, digit_cnt, fail_cnt};

  // Model: digits typed so far, password, failures, and remaining open/lock time.
  int          m_q[$];
  logic [15:0] m_pw = DPW;
  int          m_fail = 0, m_open_left = 0, m_lock_left = 0;
  bit          m_setting = 0, m_checking = 0, m_err = 0;
  bit          e_ce, e_clr;

  typedef struct packed {logic r; logic kv; logic [3:0] c;} stim_t;
  stim_t sq[$];
  stim_t s;

  function automatic logic [15:0] m_word();
    logic [15:0] w = '0;
    foreach (m_q[i]) w = {w[11:0], 4'(m_q[i])};
    return w;
  endfunction

  function automatic logic [7:0] m_regs();
    return {m_open_left > 0, m_lock_left > 0, m_err, 3'(m_q.size()), 2'(m_fail)};
  endfunction

  task automatic model_fail();
    m_err = 1;
    m_fail++;
    if (m_fail == MF) m_lock_left = L;
  endtask

  task automatic drive(input logic r, input logic kv, input logic [3:0] c);
    rst = r; key_valid = kv; key_code = c;
    e_ce = 0; e_clr = r; m_err = 0;
    if (r) begin
      m_q.delete(); m_pw = DPW; m_fail = 0; m_open_left = 0; m_lock_left = 0;
      m_setting = 0; m_checking = 0;
    end else if (m_checking) begin
      e_clr = 1; m_checking = 0;
      if (m_word() == m_pw) begin m_open_left = U; m_fail = 0; end
      else model_fail();
      m_q.delete();
    end else if (m_lock_left > 0) begin
      m_lock_left--;
      if (m_lock_left == 0) m_fail = 0;
    end else if (m_open_left > 0) begin
      if (m_open_left == 1) m_open_left = 0;
      else if (kv && c == 4'hC) begin m_open_left = 0; m_setting = 1; e_clr = 1; end
      else m_open_left--;
    end else if (kv) begin
      if (c <= 4'd9) begin
        if (m_q.size() < 4) begin e_ce = 1; m_q.push_back(int'(c)); end
      end else if (c == 4'hB) begin
        e_clr = 1; m_q.delete();
      end else if (c == 4'hA) begin
        if (m_setting) begin
          e_clr = 1;
          if (m_q.size() == 4) m_pw = m_word();
          m_q.delete(); m_setting = 0;
        end else if (m_q.size() == 4) begin
          m_checking = 1;
        end else begin
          e_clr = 1; m_q.delete(); model_fail();
        end
      end
    end
    #4;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_key(input logic [3:0] c);
    sq.push_back({1'b0, 1'b1, c});
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) sq.push_back({1'b0, 1'b0, 4'($urandom_range(0, 15))});
  endtask

  task automatic push_rst();
    sq.push_back({1'b1, 1'b0, 4'h0});
  endtask

  task automatic push_code(input logic [15:0] w);
    push_key(w[15:12]); push_key(w[11:8]); push_key(w[7:4]); push_key(w[3:0]);
    push_key(4'hA);
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 4'h5);
    n_run++;
    if ({sreg_ce, sreg_clr} !== 2'b01) begin
      n_fail++; $display("FAIL reset_comb ce/clr got %b/%b want 0/1", sreg_ce, sreg_clr);
    end
    tick();
    n_run++;
    if (w_act !== 8'h00) begin
      n_fail++; $display("FAIL reset_regs got %b want 00000000", w_act);
    end
    push_idle(3);
    while (sq.size() > 0) begin
      s = sq.pop_front(); drive(s.r, s.kv, s.c);
      n_run++;
      if ({sreg_ce, sreg_clr, sreg_din} !== {e_ce, e_clr, s.c}) begin
        n_fail++; $display("FAIL reset_idle_comb got %b want %b", {sreg_ce, sreg_clr, sreg_din}, {e_ce, e_clr, s.c});
      end
      tick();
      n_run++;
      if (w_act !== m_regs()) begin
        n_fail++; $display("FAIL reset_idle_regs got %b want %b", w_act, m_regs());
      end
    end
  endtask

  task automatic test_correct_code();
    int k = 0, first_hi = -1, hi = 0;
    push_key(4'h1); push_key(4'h2); push_key(4'h3); push_key(4'h4); push_key(4'hA);
    push_idle(U + 4);
    while (sq.size() > 0) begin
      s = sq.pop_front(); drive(s.r, s.kv, s.c);
      n_run++;
      if ({sreg_ce, sreg_clr, sreg_din} !== {e_ce, e_clr, s.c}) begin
        n_fail++; $display("FAIL correct_comb got %b want %b", {sreg_ce, sreg_clr, sreg_din}, {e_ce, e_clr, s.c});
      end
      tick();
      n_run++;
      if (w_act !== m_regs()) begin
        n_fail++; $display("FAIL correct_regs got %b want %b", w_act, m_regs());
      end
      if (unlock === 1'b1) begin
        hi++;
        if (first_hi < 0) first_hi = k;
      end
      k++;
    end
    n_run++;
    if (first_hi !== 5 || hi !== int'(U)) begin
      n_fail++; $display("FAIL correct_unlock_timing rise %0d len %0d want rise 5 len %0d", first_hi, hi, U);
    end
  endtask

  task automatic test_lockout();
    int al = 0;
    for (int t = 0; t < 3; t++) begin
      push_code(16'h1235); push_idle(1);
    end
    for (int i = 0; i < int'(L) + 4; i++) begin
      if (i % 2 == 0) push_key(4'($urandom_range(0, 9)));
      else push_idle(1);
    end
    while (sq.size() > 0) begin
      s = sq.pop_front(); drive(s.r, s.kv, s.c);
      n_run++;
      if ({sreg_ce, sreg_clr, sreg_din} !== {e_ce, e_clr, s.c}) begin
        n_fail++; $display("FAIL lockout_comb got %b want %b", {sreg_ce, sreg_clr, sreg_din}, {e_ce, e_clr, s.c});
      end
      tick();
      n_run++;
      if (w_act !== m_regs()) begin
        n_fail++; $display("FAIL lockout_regs got %b want %b", w_act, m_regs());
      end
      if (alarm === 1'b1) al++;
    end
    n_run++;
    if (al !== int'(L)) begin
      n_fail++; $display("FAIL lockout_alarm_len got %0d want %0d", al, L);
    end
    push_key(4'hB); push_idle(1);
    while (sq.size() > 0) begin
      s = sq.pop_front(); drive(s.r, s.kv, s.c); tick();
    end
  endtask

  task automatic test_short_long();
    push_key(4'h1); push_key(4'h2); push_key(4'hA); push_idle(1);
    push_key(4'h1); push_key(4'h2); push_key(4'h3); push_key(4'h4); push_key(4'h9);
    push_key(4'hA); push_idle(U + 3);
    while (sq.size() > 0) begin
      s = sq.pop_front(); drive(s.r, s.kv, s.c);
      n_run++;
      if ({sreg_ce, sreg_clr, sreg_din} !== {e_ce, e_clr, s.c}) begin
        n_fail++; $display("FAIL short_long_comb got %b want %b", {sreg_ce, sreg_clr, sreg_din}, {e_ce, e_clr, s.c});
      end
      tick();
      n_run++;
      if (w_act !== m_regs()) begin
        n_fail++; $display("FAIL short_long_regs got %b want %b", w_act, m_regs());
      end
    end
  endtask

  task automatic test_clear();
    push_key(4'h9); push_key(4'h9); push_key(4'hB);
    push_code(16'h1234); push_idle(U + 3);
    while (sq.size() > 0) begin
      s = sq.pop_front(); drive(s.r, s.kv, s.c);
      n_run++;
      if ({sreg_ce, sreg_clr, sreg_din} !== {e_ce, e_clr, s.c}) begin
        n_fail++; $display("FAIL clear_comb got %b want %b", {sreg_ce, sreg_clr, sreg_din}, {e_ce, e_clr, s.c});
      end
      tick();
      n_run++;
      if (w_act !== m_regs()) begin
        n_fail++; $display("FAIL clear_regs got %b want %b", w_act, m_regs());
      end
    end
  endtask

  task automatic test_pw_change();
    push_code(16'h1234); push_idle(2);
    push_key(4'hC); push_code(16'h5678); push_idle(1);
    push_code(16'h1234); push_idle(2);
    push_code(16'h5678); push_idle(U + 3);
    while (sq.size() > 0) begin
      s = sq.pop_front(); drive(s.r, s.kv, s.c);
      n_run++;
      if ({sreg_ce, sreg_clr, sreg_din} !== {e_ce, e_clr, s.c}) begin
        n_fail++; $display("FAIL pw_change_comb got %b want %b", {sreg_ce, sreg_clr, sreg_din}, {e_ce, e_clr, s.c});
      end
      tick();
      n_run++;
      if (w_act !== m_regs()) begin
        n_fail++; $display("FAIL pw_change_regs got %b want %b", w_act, m_regs());
      end
    end
  endtask

  task automatic test_reset_mid();
    push_code(m_pw); push_idle(3); push_rst(); push_idle(1);
    push_code(DPW); push_idle(2); push_key(4'hC); push_key(4'h5); push_key(4'h6);
    push_rst(); push_idle(1);
    push_code(DPW); push_idle(U + 3);
    while (sq.size() > 0) begin
      s = sq.pop_front(); drive(s.r, s.kv, s.c);
      n_run++;
      if ({sreg_ce, sreg_clr, sreg_din} !== {e_ce, e_clr, s.c}) begin
        n_fail++; $display("FAIL reset_mid_comb got %b want %b", {sreg_ce, sreg_clr, sreg_din}, {e_ce, e_clr, s.c});
      end
      tick();
      n_run++;
      if (w_act !== m_regs()) begin
        n_fail++; $display("FAIL reset_mid_regs got %b want %b", w_act, m_regs());
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] w;
    for (int a = 0; a < 200; a++) begin
      w = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      case ($urandom_range(0, 9))
        0, 1, 2: push_code(m_pw);
        3, 4:    push_code(w);
        5:       for (int i = 0; i < 6; i++) begin
                   if ($urandom_range(0, 1) == 1) push_key(4'($urandom_range(0, 15)));
                   else push_idle(1);
                 end
        6:       begin push_key(4'hC); push_code(w); end
        7:       push_idle(int'($urandom_range(0, 12)));
        8:       begin push_key(w[3:0]); push_key(w[7:4]); push_key(4'hA); end
        default: if ($urandom_range(0, 4) == 0) push_rst(); else push_key(4'hB);
      endcase
      while (sq.size() > 0) begin
        s = sq.pop_front(); drive(s.r, s.kv, s.c);
        n_run++;
        if ({sreg_ce, sreg_clr, sreg_din} !== {e_ce, e_clr, s.c}) begin
          n_fail++; $display("FAIL random_comb got %b want %b", {sreg_ce, sreg_clr, sreg_din}, {e_ce, e_clr, s.c});
        end
        tick();
        n_run++;
        if (w_act !== m_regs()) begin
          n_fail++; $display("FAIL random_regs got %b want %b", w_act, m_regs());
        end
      end
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_correct_code();
    test_lockout();
    test_short_long();
    test_clear();
    test_pw_change();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
